// File: rtl/wb_commit_ctrl.sv
// Write-back commit controller: holds the WB instruction, raises cp0 strobes, computes
// flush/redirect, and discards wrong-path input for DRAIN_CYCLES cycles after a flush.
module wb_commit_ctrl #(
   parameter logic [31:0] EXC_VEC      = 32'hbfc00380,
   parameter logic [31:0] REFILL_VEC   = 32'hbfc00200,
   parameter int          DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ms_to_ws_valid,
   input  logic [31:0] ms_pc,
   input  logic        ms_ex,
   input  logic [4:0]  ms_excode,
   input  logic        ms_refill,
   input  logic        ms_bd,
   input  logic [31:0] ms_badvaddr,
   input  logic        ms_eret,
   input  logic [2:0]  ms_tlb_op,
   input  logic        ms_mtc0,
   input  logic [7:0]  ms_c0_addr,
   output logic        ws_allowin,
   output logic        ws_valid,
   output logic        wb_ex,
   output logic        wb_bd,
   output logic        ws_eret,
   output logic [4:0]  wb_excode,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_badvaddr,
   output logic        tlbp,
   output logic        tlbr,
   output logic        tlbwi,
   output logic        mtc0_we,
   input  logic [31:0] cp0_status,
   input  logic [31:0] cp0_cause,
   input  logic [31:0] cp0_epc,
   output logic        flush,
   output logic [31:0] flush_pc
);

   localparam logic [3:0] DRAIN_INIT  = (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);
   localparam logic [7:0] C0_ENTRYHI  = 8'h50;
   localparam logic [7:0] C0_STATUS   = 8'h60;

   typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic        w_drain;

   logic        r_valid;
   logic [31:0] r_pc;
   logic        r_ex;
   logic [4:0]  r_excode;
   logic        r_refill;
   logic        r_bd;
   logic [31:0] r_badvaddr;
   logic        r_eret;
   logic [2:0]  r_tlb_op;
   logic        r_mtc0;
   logic [7:0]  r_c0_addr;

   logic        w_load;
   logic        w_int_req;
   logic        w_take_ex;
   logic        w_eret;
   logic        w_refetch;
   logic        w_exl;

   assign ws_allowin = 1'b1;
   assign w_load     = ms_to_ws_valid & ws_allowin & ~w_drain;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // FSM next state
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (flush && (DRAIN_CYCLES != 0)) begin
               w_state_nxt = S_DRAIN;
               w_cnt_nxt   = DRAIN_INIT;
            end
         end
         S_DRAIN: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      w_drain = 1'b0;
      if (r_state == S_DRAIN) begin
         w_drain = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_load;
      end
   end

   // Payload carries no reset; every use is qualified by r_valid.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_pc       <= ms_pc;
         r_ex       <= ms_ex;
         r_excode   <= ms_excode;
         r_refill   <= ms_refill;
         r_bd       <= ms_bd;
         r_badvaddr <= ms_badvaddr;
         r_eret     <= ms_eret;
         r_tlb_op   <= ms_tlb_op;
         r_mtc0     <= ms_mtc0;
         r_c0_addr  <= ms_c0_addr;
      end
   end

   assign w_exl     = cp0_status[1];
   assign w_int_req = cp0_status[0] & ~w_exl & (|(cp0_cause[15:8] & cp0_status[15:8]));
   assign w_take_ex = r_valid & (r_ex | w_int_req);
   assign w_eret    = r_valid & r_eret & ~w_take_ex;
   assign w_refetch = r_valid & ~w_take_ex & ~r_eret &
                      (r_tlb_op[1] | r_tlb_op[0] |
                       (r_mtc0 & ((r_c0_addr == C0_ENTRYHI) | (r_c0_addr == C0_STATUS))));

   assign ws_valid    = r_valid;
   assign wb_ex       = w_take_ex;
   assign wb_bd       = r_valid & r_bd;
   assign ws_eret     = w_eret;
   assign wb_excode   = (r_valid & r_ex) ? r_excode : 5'h00;
   assign wb_pc       = r_valid ? r_pc : 32'h0;
   assign wb_badvaddr = r_valid ? r_badvaddr : 32'h0;
   assign tlbp        = r_valid & r_tlb_op[2] & ~w_take_ex;
   assign tlbr        = r_valid & r_tlb_op[1] & ~w_take_ex;
   assign tlbwi       = r_valid & r_tlb_op[0] & ~w_take_ex;
   assign mtc0_we     = r_valid & r_mtc0 & ~w_take_ex;
   assign flush       = w_take_ex | w_eret | w_refetch;

   // A refetch from a delay slot restarts at the branch so the branch re-resolves.
   always_comb begin
      flush_pc = 32'h0;
      if (w_take_ex) begin
         flush_pc = (r_ex & r_refill & ~w_exl) ? REFILL_VEC : EXC_VEC;
      end else if (w_eret) begin
         flush_pc = cp0_epc;
      end else if (w_refetch) begin
         flush_pc = r_bd ? (r_pc - 32'd4) : (r_pc + 32'd4);
      end
   end

endmodule

// File: tb/tb_wb_commit_ctrl.sv
// Directed bench for wb_commit_ctrl: each task drives one scenario and checks
// commit-cycle outputs against hand-computed values.
module tb_wb_commit_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ms_to_ws_valid;
   logic [31:0] ms_pc;
   logic        ms_ex;
   logic [4:0]  ms_excode;
   logic        ms_refill;
   logic        ms_bd;
   logic [31:0] ms_badvaddr;
   logic        ms_eret;
   logic [2:0]  ms_tlb_op;
   logic        ms_mtc0;
   logic [7:0]  ms_c0_addr;
   logic        ws_allowin, ws_valid, wb_ex, wb_bd, ws_eret;
   logic [4:0]  wb_excode;
   logic [31:0] wb_pc, wb_badvaddr;
   logic        tlbp, tlbr, tlbwi, mtc0_we;
   logic [31:0] cp0_status, cp0_cause, cp0_epc;
   logic        flush;
   logic [31:0] flush_pc;

   int checks = 0;
   int failures = 0;

   wb_commit_ctrl dut (
      .clk(clk), .rst(rst),
      .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_ex(ms_ex),
      .ms_excode(ms_excode), .ms_refill(ms_refill), .ms_bd(ms_bd),
      .ms_badvaddr(ms_badvaddr), .ms_eret(ms_eret), .ms_tlb_op(ms_tlb_op),
      .ms_mtc0(ms_mtc0), .ms_c0_addr(ms_c0_addr),
      .ws_allowin(ws_allowin), .ws_valid(ws_valid), .wb_ex(wb_ex), .wb_bd(wb_bd),
      .ws_eret(ws_eret), .wb_excode(wb_excode), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
      .tlbp(tlbp), .tlbr(tlbr), .tlbwi(tlbwi), .mtc0_we(mtc0_we),
      .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
      .flush(flush), .flush_pc(flush_pc)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input [31:0] pc, input ex, input [4:0] code, input refill,
                            input bd, input [31:0] bva, input eret, input [2:0] tlb,
                            input mtc0, input [7:0] addr);
      ms_to_ws_valid = 1'b1;
      ms_pc = pc; ms_ex = ex; ms_excode = code; ms_refill = refill; ms_bd = bd;
      ms_badvaddr = bva; ms_eret = eret; ms_tlb_op = tlb; ms_mtc0 = mtc0; ms_c0_addr = addr;
   endtask

   // Offer one instruction for one cycle; returns in its WB commit cycle.
   task automatic commit(input [31:0] pc, input ex, input [4:0] code, input refill,
                         input bd, input [31:0] bva, input eret, input [2:0] tlb,
                         input mtc0, input [7:0] addr);
      set_instr(pc, ex, code, refill, bd, bva, eret, tlb, mtc0, addr);
      step();
      ms_to_ws_valid = 1'b0;
   endtask

   task automatic idle_inputs();
      ms_to_ws_valid = 1'b0; ms_pc = '0; ms_ex = 1'b0; ms_excode = '0; ms_refill = 1'b0;
      ms_bd = 1'b0; ms_badvaddr = '0; ms_eret = 1'b0; ms_tlb_op = '0; ms_mtc0 = 1'b0;
      ms_c0_addr = '0; cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      step(); step();
      checks++;
      if ({ws_valid, wb_ex, flush, ws_allowin, flush_pc} !== {4'b0001, 32'h0}) begin
         failures++;
         $display("FAIL reset_hold got=%b/%h exp=0001/0", {ws_valid, wb_ex, flush, ws_allowin}, flush_pc);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if ({ws_valid, wb_ex, flush, ws_allowin, tlbwi, mtc0_we, ws_eret} !== 7'b0001000) begin
            failures++;
            $display("FAIL reset_idle cyc%0d got=%b exp=0001000", i,
                     {ws_valid, wb_ex, flush, ws_allowin, tlbwi, mtc0_we, ws_eret});
         end
      end
   endtask

   task automatic test_exception_drain();
      commit(32'hbfc00100, 1'b1, 5'h04, 1'b0, 1'b0, 32'h1003, 1'b0, 3'b000, 1'b0, 8'h00);
      checks++;
      if ({wb_ex, wb_excode, wb_badvaddr, flush, flush_pc} !== {1'b1, 5'h04, 32'h1003, 1'b1, 32'hbfc00380}) begin
         failures++;
         $display("FAIL exc_commit got ex=%b code=%h bva=%h fl=%b pc=%h exp 1 04 00001003 1 bfc00380",
                  wb_ex, wb_excode, wb_badvaddr, flush, flush_pc);
      end
      step();
      set_instr(32'h00000a00, 1'b0, 5'h0, 1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 8'h00);
      step();
      checks++;
      if (ws_valid !== 1'b0) begin
         failures++;
         $display("FAIL drain_drop1 ws_valid got=%b exp=0", ws_valid);
      end
      ms_pc = 32'h00000b00;
      step();
      checks++;
      if (ws_valid !== 1'b0) begin
         failures++;
         $display("FAIL drain_drop2 ws_valid got=%b exp=0", ws_valid);
      end
      ms_pc = 32'h00000c00;
      step();
      checks++;
      if ({ws_valid, wb_pc, flush} !== {1'b1, 32'h00000c00, 1'b0}) begin
         failures++;
         $display("FAIL drain_third_loads got v=%b pc=%h fl=%b exp 1 00000c00 0", ws_valid, wb_pc, flush);
      end
      ms_to_ws_valid = 1'b0;
      step();
   endtask

   task automatic test_refill();
      commit(32'hbfc00200, 1'b1, 5'h02, 1'b1, 1'b0, 32'h2000, 1'b0, 3'b000, 1'b0, 8'h00);
      checks++;
      if ({flush, flush_pc} !== {1'b1, 32'hbfc00200}) begin
         failures++;
         $display("FAIL refill_exl0 got fl=%b pc=%h exp 1 bfc00200", flush, flush_pc);
      end
      step(); step(); step();
      cp0_status = 32'h0000_0002;
      commit(32'hbfc00204, 1'b1, 5'h02, 1'b1, 1'b0, 32'h2000, 1'b0, 3'b000, 1'b0, 8'h00);
      checks++;
      if ({flush, flush_pc, wb_excode} !== {1'b1, 32'hbfc00380, 5'h02}) begin
         failures++;
         $display("FAIL refill_exl1 got fl=%b pc=%h code=%h exp 1 bfc00380 02", flush, flush_pc, wb_excode);
      end
      step(); step(); step();
      cp0_status = '0;
   endtask

   task automatic test_interrupt();
      cp0_status = 32'h0000_8001;
      cp0_cause  = 32'h0000_8000;
      commit(32'hbfc01000, 1'b0, 5'h00, 1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b1, 8'h60);
      checks++;
      if ({wb_ex, wb_excode, wb_pc, mtc0_we, flush, flush_pc} !==
          {1'b1, 5'h00, 32'hbfc01000, 1'b0, 1'b1, 32'hbfc00380}) begin
         failures++;
         $display("FAIL int_take got ex=%b code=%h pc=%h we=%b fl=%b fpc=%h exp 1 00 bfc01000 0 1 bfc00380",
                  wb_ex, wb_excode, wb_pc, mtc0_we, flush, flush_pc);
      end
      step(); step(); step();
      // EXL set masks the interrupt; the mtc0 to Status then refetches.
      cp0_status = 32'h0000_8003;
      commit(32'hbfc01000, 1'b0, 5'h00, 1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b1, 8'h60);
      checks++;
      if ({wb_ex, mtc0_we, flush, flush_pc} !== {1'b0, 1'b1, 1'b1, 32'hbfc01004}) begin
         failures++;
         $display("FAIL int_exl_masked got ex=%b we=%b fl=%b fpc=%h exp 0 1 1 bfc01004",
                  wb_ex, mtc0_we, flush, flush_pc);
      end
      step(); step(); step();
      cp0_status = 32'h0000_8001;
      commit(32'hbfc01100, 1'b1, 5'h0a, 1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 8'h00);
      checks++;
      if ({wb_ex, wb_excode} !== {1'b1, 5'h0a}) begin
         failures++;
         $display("FAIL int_vs_instr_ex got ex=%b code=%h exp 1 0a", wb_ex, wb_excode);
      end
      step(); step(); step();
      cp0_epc = 32'h80005555;
      commit(32'hbfc01200, 1'b0, 5'h00, 1'b0, 1'b0, 32'h0, 1'b1, 3'b001, 1'b0, 8'h00);
      checks++;
      if ({wb_ex, ws_eret, tlbwi, flush_pc} !== {1'b1, 1'b0, 1'b0, 32'hbfc00380}) begin
         failures++;
         $display("FAIL int_beats_eret got ex=%b eret=%b tlbwi=%b fpc=%h exp 1 0 0 bfc00380",
                  wb_ex, ws_eret, tlbwi, flush_pc);
      end
      step(); step(); step();
      cp0_status = '0;
      cp0_cause  = '0;
   endtask

   task automatic test_refetch_eret();
      commit(32'hbfc02000, 1'b0, 5'h00, 1'b0, 1'b0, 32'h0, 1'b0, 3'b001, 1'b0, 8'h00);
      checks++;
      if ({tlbwi, tlbr, tlbp, flush, flush_pc} !== {3'b100, 1'b1, 32'hbfc02004}) begin
         failures++;
         $display("FAIL tlbwi_refetch got w/r/p=%b fl=%b fpc=%h exp 100 1 bfc02004",
                  {tlbwi, tlbr, tlbp}, flush, flush_pc);
      end
      step(); step(); step();
      commit(32'hbfc02000, 1'b0, 5'h00, 1'b0, 1'b1, 32'h0, 1'b0, 3'b001, 1'b0, 8'h00);
      checks++;
      if ({wb_bd, flush, flush_pc} !== {1'b1, 1'b1, 32'hbfc01ffc}) begin
         failures++;
         $display("FAIL tlbwi_bd got bd=%b fl=%b fpc=%h exp 1 1 bfc01ffc", wb_bd, flush, flush_pc);
      end
      step(); step(); step();
      commit(32'hfffffffc, 1'b0, 5'h00, 1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b1, 8'h50);
      checks++;
      if ({mtc0_we, flush, flush_pc} !== {1'b1, 1'b1, 32'h00000000}) begin
         failures++;
         $display("FAIL entryhi_wrap got we=%b fl=%b fpc=%h exp 1 1 00000000", mtc0_we, flush, flush_pc);
      end
      step(); step(); step();
      commit(32'hbfc02100, 1'b0, 5'h00, 1'b0, 1'b0, 32'h0, 1'b0, 3'b100, 1'b1, 8'h58);
      checks++;
      if ({tlbp, mtc0_we, flush} !== 3'b110) begin
         failures++;
         $display("FAIL no_refetch got tlbp/we/fl=%b exp 110", {tlbp, mtc0_we, flush});
      end
      step();
      cp0_epc = 32'h80001234;
      commit(32'hbfc02200, 1'b0, 5'h00, 1'b0, 1'b0, 32'h0, 1'b1, 3'b000, 1'b0, 8'h00);
      checks++;
      if ({ws_eret, wb_ex, flush, flush_pc} !== {1'b1, 1'b0, 1'b1, 32'h80001234}) begin
         failures++;
         $display("FAIL eret got eret=%b ex=%b fl=%b fpc=%h exp 1 0 1 80001234", ws_eret, wb_ex, flush, flush_pc);
      end
      step(); step(); step();
   endtask

   task automatic test_reset_midway();
      commit(32'hbfc03000, 1'b1, 5'h04, 1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 8'h00);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({ws_valid, flush, wb_ex} !== 3'b000) begin
         failures++;
         $display("FAIL rst_mid_commit got v/fl/ex=%b exp 000", {ws_valid, flush, wb_ex});
      end
      rst = 1'b0;
      commit(32'hbfc03100, 1'b1, 5'h04, 1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 8'h00);
      step();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      set_instr(32'hbfc03200, 1'b0, 5'h0, 1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 8'h00);
      step();
      checks++;
      if ({ws_valid, wb_pc} !== {1'b1, 32'hbfc03200}) begin
         failures++;
         $display("FAIL rst_mid_drain got v=%b pc=%h exp 1 bfc03200", ws_valid, wb_pc);
      end
      ms_to_ws_valid = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_exception_drain();
      test_refill();
      test_interrupt();
      test_refetch_eret();
      test_reset_midway();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
